// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the SoC console UART arbiter.
package mini16_uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] DEFAULT_EOL_CHAR = 8'h0A;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer, with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;

  always_comb begin
    w_rot   = '0;
    w_off   = '0;
    o_found = 1'b0;
    // Rotate so bit 0 is the requester just after the pointer.
    for (int i = 0; i < N; i++) begin
      w_rot[i] = i_req[IDX_W'((int'(i_ptr) + 1 + i) % N)];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
    o_idx = IDX_W'((int'(i_ptr) + 1 + int'(w_off)) % N);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-atomic round-robin arbiter sharing the console UART TX FIFO among byte producers.
module uart_tx_arbiter
  import mini16_uart_arb_pkg::*;
#(
  parameter int                    REQUESTERS = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR   = DATA_WIDTH'(DEFAULT_EOL_CHAR),
  parameter int                    MAX_BURST  = 64,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [REQUESTERS-1:0]                req_valid,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]     req_data,
  output logic [REQUESTERS-1:0]                req_ready,
  output logic                                 tx_valid,
  output logic [DATA_WIDTH-1:0]                tx_data,
  input  logic                                 tx_ready,
  output logic [clog2_min1(REQUESTERS)-1:0]    grant_id,
  output logic                                 busy
);

  localparam int IDX_W   = clog2_min1(REQUESTERS);
  localparam int BURST_W = clog2_min1(MAX_BURST + 1);
  localparam int TO_W    = clog2_min1(TIMEOUT + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_grant_id;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_busy;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [TO_W-1:0]    r_to_cnt;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_owner_valid;
  logic               w_xfer;
  logic               w_eol;
  logic               w_burst_end;
  logic               w_to_end;
  logic               w_release;

  rr_pick #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Zero-latency pass-through from the current owner.
  assign w_owner_valid = req_valid[r_grant_id];
  assign tx_valid      = (r_state == GRANT) && w_owner_valid;
  assign tx_data       = req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (r_state == GRANT) req_ready[r_grant_id] = tx_ready;
  end

  assign w_xfer      = tx_valid && tx_ready;
  assign w_eol       = w_xfer && (tx_data == EOL_CHAR);
  assign w_burst_end = w_xfer && (r_burst_cnt == BURST_LAST);
  // Release on the idle cycle that brings the stall count up to TIMEOUT.
  assign w_to_end    = (TIMEOUT != 0) && (r_state == GRANT) && !w_owner_valid
                       && (r_to_cnt == TO_LAST);
  assign w_release   = w_eol || w_burst_end || w_to_end;

  assign busy     = r_busy;
  assign grant_id = r_grant_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_grant_id  <= '0;
      r_ptr       <= IDX_W'(REQUESTERS - 1);
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_grant_id  <= w_pick_idx;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
            r_to_cnt    <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= r_grant_id;
          end
          if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_to_cnt    <= '0;
          end else if (!w_owner_valid && (r_to_cnt != '1)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
